// File: rtl/game_pkg.sv
// Shared game definitions: action codes, player IDs and the per-player pending slot.
package game_pkg;

    localparam int unsigned CODE_W = 2;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [CODE_W-1:0] {
        ACT_NONE   = 2'b00,
        ACT_LEFT   = 2'b01,
        ACT_RIGHT  = 2'b10,
        ACT_ATTACK = 2'b11
    } act_code_t;

    typedef enum logic {
        PLAYER_1 = 1'b0,
        PLAYER_2 = 1'b1
    } player_t;

    typedef struct packed {
        logic      valid;
        act_code_t code;
    } slot_t;

    // Direction is only meaningful when exactly one of left/right is pressed.
    function automatic act_code_t dir_of(input logic left, input logic right);
        if (left && !right) begin
            return ACT_LEFT;
        end
        if (right && !left) begin
            return ACT_RIGHT;
        end
        return ACT_NONE;
    endfunction

endpackage

// File: rtl/player_action_gen.sv
// One player's action source: direction auto-repeat, attack edge detect with
// cooldown, and a single pending-action slot drained by the arbiter.
module player_action_gen
    import game_pkg::*;
#(
    parameter int unsigned MOVE_PERIOD     = 8,
    parameter int unsigned ATTACK_COOLDOWN = 16
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  tick,
    input  logic  left,
    input  logic  right,
    input  logic  attack,
    input  logic  grant,
    output slot_t slot,
    output logic  cooldown
);

    act_code_t        dir;
    act_code_t        prev_dir;
    logic             prev_attack;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_next;
    logic [CNT_W-1:0] cd_cnt;
    logic [CNT_W-1:0] cd_next;
    logic             new_dir;
    logic             move_req;
    logic             attack_req;
    slot_t            slot_next;

    // Request generation, counter updates and slot replacement policy.
    always_comb begin
        dir        = dir_of(left, right);
        new_dir    = 1'b0;
        move_req   = 1'b0;
        attack_req = 1'b0;
        rep_next   = rep_cnt;
        cd_next    = cd_cnt;
        slot_next  = slot;

        new_dir  = (dir != ACT_NONE) && (dir != prev_dir);
        move_req = new_dir || ((dir != ACT_NONE) && tick && (rep_cnt == CNT_W'(1)));

        if (dir == ACT_NONE) begin
            rep_next = '0;
        end else if (new_dir) begin
            rep_next = CNT_W'(MOVE_PERIOD);
        end else if (tick) begin
            if (rep_cnt == CNT_W'(1)) begin
                rep_next = CNT_W'(MOVE_PERIOD);
            end else if (rep_cnt != '0) begin
                rep_next = rep_cnt - CNT_W'(1);
            end
        end

        attack_req = attack && !prev_attack && (cd_cnt == '0);

        if (grant && (slot.code == ACT_ATTACK)) begin
            cd_next = CNT_W'(ATTACK_COOLDOWN);
        end else if (tick && (cd_cnt != '0)) begin
            cd_next = cd_cnt - CNT_W'(1);
        end

        // Clear first so a same-cycle request survives the grant.
        if (grant) begin
            slot_next.valid = 1'b0;
        end
        if (move_req && !slot_next.valid) begin
            slot_next = '{valid: 1'b1, code: dir};
        end
        if (attack_req) begin
            slot_next = '{valid: 1'b1, code: ACT_ATTACK};
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_dir    <= ACT_NONE;
            prev_attack <= 1'b0;
            rep_cnt     <= '0;
            cd_cnt      <= '0;
            slot        <= '{valid: 1'b0, code: ACT_NONE};
            cooldown    <= 1'b0;
        end else begin
            prev_dir    <= dir;
            prev_attack <= attack;
            rep_cnt     <= rep_next;
            cd_cnt      <= cd_next;
            slot        <= slot_next;
            cooldown    <= (cd_next != '0);
        end
    end

endmodule

// File: rtl/player_action_arbiter.sv
// Two-player action arbiter: round-robin between the players' pending slots
// into a single valid/ready output register.
module player_action_arbiter
    import game_pkg::*;
#(
    parameter int unsigned MOVE_PERIOD     = 8,
    parameter int unsigned ATTACK_COOLDOWN = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              p1_left,
    input  logic              p1_right,
    input  logic              p1_attack,
    input  logic              p2_left,
    input  logic              p2_right,
    input  logic              p2_attack,
    input  logic              act_ready,
    output logic              act_valid,
    output logic              act_player,
    output logic [CODE_W-1:0] act_code,
    output logic              p1_cooldown,
    output logic              p2_cooldown
);

    slot_t   slot_p1;
    slot_t   slot_p2;
    player_t last_grant;
    player_t pick_c;
    logic    free_c;
    logic    grant_p1_c;
    logic    grant_p2_c;
    logic    load_c;

    player_action_gen #(
        .MOVE_PERIOD     (MOVE_PERIOD),
        .ATTACK_COOLDOWN (ATTACK_COOLDOWN)
    ) u_gen_p1 (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .left     (p1_left),
        .right    (p1_right),
        .attack   (p1_attack),
        .grant    (grant_p1_c),
        .slot     (slot_p1),
        .cooldown (p1_cooldown)
    );

    player_action_gen #(
        .MOVE_PERIOD     (MOVE_PERIOD),
        .ATTACK_COOLDOWN (ATTACK_COOLDOWN)
    ) u_gen_p2 (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .left     (p2_left),
        .right    (p2_right),
        .attack   (p2_attack),
        .grant    (grant_p2_c),
        .slot     (slot_p2),
        .cooldown (p2_cooldown)
    );

    // Pick a pending slot whenever the output register can take a new action.
    always_comb begin
        free_c     = !act_valid || act_ready;
        pick_c     = PLAYER_1;
        grant_p1_c = 1'b0;
        grant_p2_c = 1'b0;

        if (free_c) begin
            if (slot_p1.valid && slot_p2.valid) begin
                pick_c = (last_grant == PLAYER_1) ? PLAYER_2 : PLAYER_1;
            end else if (slot_p2.valid) begin
                pick_c = PLAYER_2;
            end
            grant_p1_c = slot_p1.valid && (pick_c == PLAYER_1);
            grant_p2_c = slot_p2.valid && (pick_c == PLAYER_2);
        end
        load_c = grant_p1_c || grant_p2_c;
    end

    // Output register; holds its payload while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_valid  <= 1'b0;
            act_player <= 1'b0;
            act_code   <= CODE_W'(ACT_NONE);
            last_grant <= PLAYER_2;
        end else if (free_c) begin
            act_valid <= load_c;
            if (load_c) begin
                act_player <= pick_c;
                act_code   <= (pick_c == PLAYER_1) ? slot_p1.code : slot_p2.code;
                last_grant <= pick_c;
            end
        end
    end

endmodule

// File: tb/tb_player_action_arbiter.sv
// Bench for player_action_arbiter: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the game rules.
module tb_player_action_arbiter;

    localparam int unsigned MP = 4;
    localparam int unsigned AC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       p1_left = 1'b0, p1_right = 1'b0, p1_attack = 1'b0;
    logic       p2_left = 1'b0, p2_right = 1'b0, p2_attack = 1'b0;
    logic       act_ready = 1'b1;
    logic       act_valid;
    logic       act_player;
    logic [1:0] act_code;
    logic       p1_cooldown, p2_cooldown;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: per player held direction, repeat count, cooldown, slot.
    int m_prev_dir [2];
    int m_prev_att [2];
    int m_rep      [2];
    int m_cd       [2];
    bit m_slot_v   [2];
    int m_slot_code[2];
    bit m_valid;
    int m_player;
    int m_code;
    int m_last;

    player_action_arbiter #(
        .MOVE_PERIOD     (MP),
        .ATTACK_COOLDOWN (AC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .p1_left     (p1_left),
        .p1_right    (p1_right),
        .p1_attack   (p1_attack),
        .p2_left     (p2_left),
        .p2_right    (p2_right),
        .p2_attack   (p2_attack),
        .act_ready   (act_ready),
        .act_valid   (act_valid),
        .act_player  (act_player),
        .act_code    (act_code),
        .p1_cooldown (p1_cooldown),
        .p2_cooldown (p2_cooldown)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic int dir_num(input logic l, input logic r);
        if (l && !r) return 1;
        if (r && !l) return 2;
        return 0;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        int  dir   [2];
        bit  att   [2];
        bit  req_m [2];
        bit  req_a [2];
        int  g;
        if (reset) begin
            for (int p = 0; p < 2; p++) begin
                m_prev_dir[p] = 0; m_prev_att[p] = 0; m_rep[p] = 0; m_cd[p] = 0;
                m_slot_v[p] = 0; m_slot_code[p] = 0;
            end
            m_valid = 0; m_player = 0; m_code = 0; m_last = 1;
            return;
        end
        dir[0] = dir_num(p1_left, p1_right);
        dir[1] = dir_num(p2_left, p2_right);
        att[0] = p1_attack;
        att[1] = p2_attack;
        for (int p = 0; p < 2; p++) begin
            req_m[p] = (dir[p] != 0) && ((dir[p] != m_prev_dir[p]) || (tick && m_rep[p] == 1));
            if (dir[p] == 0)                 m_rep[p] = 0;
            else if (dir[p] != m_prev_dir[p]) m_rep[p] = MP;
            else if (tick)                    m_rep[p] = (m_rep[p] == 1) ? MP : (m_rep[p] > 0 ? m_rep[p] - 1 : 0);
            m_prev_dir[p] = dir[p];
            req_a[p] = att[p] && (m_prev_att[p] == 0) && (m_cd[p] == 0);
            m_prev_att[p] = att[p];
        end
        g = -1;
        if (!m_valid || act_ready) begin
            if (m_slot_v[0] && m_slot_v[1]) g = (m_last == 0) ? 1 : 0;
            else if (m_slot_v[0])           g = 0;
            else if (m_slot_v[1])           g = 1;
            if (g >= 0) begin
                m_valid = 1; m_player = g; m_code = m_slot_code[g]; m_last = g;
                m_slot_v[g] = 0;
            end else begin
                m_valid = 0;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (g == p && m_code == 3) m_cd[p] = AC;
            else if (tick && m_cd[p] > 0) m_cd[p] = m_cd[p] - 1;
            if (req_m[p] && !m_slot_v[p]) begin m_slot_v[p] = 1; m_slot_code[p] = dir[p]; end
            if (req_a[p])                 begin m_slot_v[p] = 1; m_slot_code[p] = 3; end
        end
    endtask

    task automatic compare_all();
        check_eq("act_valid", 32'(act_valid), 32'(m_valid));
        if (m_valid) begin
            check_eq("act_player", 32'(act_player), 32'(m_player));
            check_eq("act_code", 32'(act_code), 32'(m_code));
        end
        check_eq("p1_cooldown", 32'(p1_cooldown), 32'(m_cd[0] != 0));
        check_eq("p2_cooldown", 32'(p2_cooldown), 32'(m_cd[1] != 0));
    endtask

    // One clock: model follows the edge, outputs compared just after it.
    task automatic run_cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic release_all();
        p1_left = 0; p1_right = 0; p1_attack = 0;
        p2_left = 0; p2_right = 0; p2_attack = 0;
        tick = 0;
    endtask

    task automatic pulse_reset();
        reset = 1;
        run_cycle();
        reset = 0;
        run_cycle();
    endtask

    initial begin
        int cnt;
        run_cycle();
        run_cycle();
        check_eq("rst_valid", 32'(act_valid), 32'd0);
        check_eq("rst_player", 32'(act_player), 32'd0);
        check_eq("rst_code", 32'(act_code), 32'd0);
        check_eq("rst_cd", 32'({p1_cooldown, p2_cooldown}), 32'd0);
        reset = 0;
        run_cycle();

        // Held right: first action two cycles after press, repeats on ticks 4 and 8.
        p1_right = 1;
        run_cycle();
        run_cycle();
        check_eq("rep_first_valid", 32'(act_valid), 32'd1);
        check_eq("rep_first_code", 32'(act_code), 32'd2);
        check_eq("rep_first_player", 32'(act_player), 32'd0);
        cnt = 1;
        for (int t = 1; t <= 10; t++) begin
            tick = 1; run_cycle(); if (act_valid) cnt++;
            tick = 0; run_cycle(); if (act_valid) cnt++;
            run_cycle(); if (act_valid) cnt++;
        end
        check_eq("rep_count", 32'(cnt), 32'd3);
        release_all();
        repeat (3) run_cycle();

        // Simultaneous attacks after reset: player 1 first, then player 2.
        pulse_reset();
        p1_attack = 1; p2_attack = 1;
        run_cycle();
        run_cycle();
        check_eq("tie_first_player", 32'(act_player), 32'd0);
        check_eq("tie_first_code", 32'(act_code), 32'd3);
        run_cycle();
        check_eq("tie_second_valid", 32'(act_valid), 32'd1);
        check_eq("tie_second_player", 32'(act_player), 32'd1);
        check_eq("tie_second_code", 32'(act_code), 32'd3);
        for (int i = 1; i <= 8; i++) begin
            tick = 1;
            run_cycle();
            if (i == 7) check_eq("cd_held_7", 32'({p1_cooldown, p2_cooldown}), 32'd3);
            if (i == 8) check_eq("cd_clear_8", 32'({p1_cooldown, p2_cooldown}), 32'd0);
        end
        release_all();
        run_cycle();

        // Attack re-press during cooldown is dropped, after cooldown accepted.
        p1_attack = 1;
        run_cycle();
        run_cycle();
        check_eq("cd_grant", 32'({act_valid, act_code}), 32'h7);
        p1_attack = 0;
        tick = 1;
        repeat (3) run_cycle();
        tick = 0; p1_attack = 1;
        cnt = 0;
        repeat (3) begin run_cycle(); if (act_valid) cnt++; end
        check_eq("cd_drop", 32'(cnt), 32'd0);
        p1_attack = 0; tick = 1;
        repeat (6) run_cycle();
        tick = 0; p1_attack = 1;
        run_cycle();
        run_cycle();
        check_eq("cd_after", 32'({act_valid, act_player, act_code}), 32'hB);
        release_all();
        repeat (2) run_cycle();

        // Back-pressure: stalled left stays put, player 2 wins after ready rises.
        act_ready = 0; p1_left = 1;
        run_cycle();
        run_cycle();
        p2_attack = 1;
        repeat (5) run_cycle();
        check_eq("stall_payload", 32'({act_valid, act_player, act_code}), 32'h9);
        act_ready = 1;
        run_cycle();
        check_eq("stall_next", 32'({act_valid, act_player, act_code}), 32'hF);
        release_all();
        repeat (3) run_cycle();

        // Both directions held is no direction; releasing one yields a move.
        p1_left = 1; p1_right = 1;
        cnt = 0;
        repeat (4) begin run_cycle(); if (act_valid) cnt++; end
        check_eq("both_dirs", 32'(cnt), 32'd0);
        p1_right = 0;
        run_cycle();
        run_cycle();
        check_eq("release_one", 32'({act_valid, act_player, act_code}), 32'h9);
        release_all();
        repeat (3) run_cycle();

        // Reset mid-handshake drops the action immediately, nothing replayed.
        act_ready = 0; p2_left = 1;
        run_cycle();
        run_cycle();
        check_eq("pre_reset", 32'({act_valid, act_player, act_code}), 32'hD);
        p2_left = 0;
        run_cycle();
        reset = 1;
        #1;
        check_eq("reset_drop", 32'(act_valid), 32'd0);
        run_cycle();
        reset = 0; act_ready = 1;
        cnt = 0;
        repeat (6) begin run_cycle(); if (act_valid) cnt++; end
        check_eq("no_replay", 32'(cnt), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(7) == 0) p1_left   = ~p1_left;
            if ($urandom_range(7) == 0) p1_right  = ~p1_right;
            if ($urandom_range(5) == 0) p1_attack = ~p1_attack;
            if ($urandom_range(7) == 0) p2_left   = ~p2_left;
            if ($urandom_range(7) == 0) p2_right  = ~p2_right;
            if ($urandom_range(5) == 0) p2_attack = ~p2_attack;
            tick      = ($urandom_range(2) == 0);
            act_ready = ($urandom_range(3) != 0);
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
